// File: rtl/arbitro_sumador_pkg.sv
// Shared widths and FSM encoding for the two-requester arbiter with a
// 4-bit adder datapath; imported by the RTL and the bench.
package arbitro_sumador_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        CALCULO = 2'd1,
        ESPERA  = 2'd2
    } estado_t;

endpackage

// File: rtl/arbitro_sumador_sumador.sv
// Combinational modulo-2^OP_W adder; the carry out is dropped by truncation.
module arbitro_sumador_sumador
    import arbitro_sumador_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] res
);

    assign res = a + b;

endmodule

// File: rtl/arbitro_sumador.sv
// Two-requester round-robin arbiter: latches the winner's operands, adds them
// and holds grant/done until the winner drops its request.
module arbitro_sumador
    import arbitro_sumador_pkg::*;
#(
    parameter logic PRIO_INICIAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [OP_W-1:0]   a0,
    input  logic [OP_W-1:0]   b0,
    input  logic              req1,
    input  logic [OP_W-1:0]   a1,
    input  logic [OP_W-1:0]   b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [OP_W-1:0]   res,
    output logic [CNT_W-1:0]  cuenta
);

    estado_t            estado_q, estado_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic [OP_W-1:0]    res_q, res_d;
    logic [CNT_W-1:0]   cuenta_q, cuenta_d;
    logic               prio_q, prio_d;    // 1: requester 1 wins a tie
    logic [OP_W-1:0]    op_a_q, op_a_d;
    logic [OP_W-1:0]    op_b_q, op_b_d;
    logic [OP_W-1:0]    suma;

    arbitro_sumador_sumador u_sumador (
        .a   (op_a_q),
        .b   (op_b_q),
        .res (suma)
    );

    always_comb begin
        estado_d = estado_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        res_d    = res_q;
        cuenta_d = cuenta_q;
        prio_d   = prio_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;

        case (estado_q)
            LIBRE: begin
                if (req0 && (!req1 || !prio_q)) begin
                    gnt0_d   = 1'b1;
                    op_a_d   = a0;
                    op_b_d   = b0;
                    estado_d = CALCULO;
                end else if (req1) begin
                    gnt1_d   = 1'b1;
                    op_a_d   = a1;
                    op_b_d   = b1;
                    estado_d = CALCULO;
                end
            end
            CALCULO: begin
                res_d    = suma;
                done0_d  = gnt0_q;
                done1_d  = gnt1_q;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // Leave only once the winner has released its request.
                if ((gnt0_q && !req0) || (gnt1_q && !req1)) begin
                    gnt0_d   = 1'b0;
                    gnt1_d   = 1'b0;
                    done0_d  = 1'b0;
                    done1_d  = 1'b0;
                    prio_d   = gnt0_q;
                    cuenta_d = cuenta_q + CNT_W'(1);
                    estado_d = LIBRE;
                end
            end
            default: begin
                gnt0_d   = 1'b0;
                gnt1_d   = 1'b0;
                done0_d  = 1'b0;
                done1_d  = 1'b0;
                estado_d = LIBRE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= LIBRE;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            res_q    <= '0;
            cuenta_q <= '0;
            prio_q   <= PRIO_INICIAL;
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            estado_q <= estado_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            res_q    <= res_d;
            cuenta_q <= cuenta_d;
            prio_q   <= prio_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign res    = res_q;
    assign cuenta = cuenta_q;

endmodule
